// File: rtl/muldiv_div_scheduler.sv
// Round-robin scheduler sharing one pipelined signed/unsigned divider pair between two requesters.
// Special cases bypass the dividers but still ride the tracking pipe so responses stay in order.
module muldiv_div_scheduler #(
  parameter int unsigned DIV_LATENCY = 20,
  parameter int unsigned TAG_W       = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic [1:0]       i_req_valid,
  output logic [1:0]       o_req_ready,
  input  logic [1:0]       i_req_op0,
  input  logic [1:0]       i_req_op1,
  input  logic [31:0]      i_req_a0,
  input  logic [31:0]      i_req_a1,
  input  logic [31:0]      i_req_b0,
  input  logic [31:0]      i_req_b1,
  input  logic [TAG_W-1:0] i_req_tag0,
  input  logic [TAG_W-1:0] i_req_tag1,
  output logic [31:0]      o_div_numer,
  output logic [31:0]      o_div_denom,
  input  logic [31:0]      i_sq,
  input  logic [31:0]      i_sr,
  input  logic [31:0]      i_uq,
  input  logic [31:0]      i_ur,
  output logic             o_rsp_valid,
  output logic             o_rsp_id,
  output logic [TAG_W-1:0] o_rsp_tag,
  output logic [31:0]      o_rsp_data,
  output logic             o_rsp_dbz,
  output logic             o_busy
);

  localparam int unsigned Depth = DIV_LATENCY + 1;

  typedef enum logic [1:0] {OpDiv = 2'd0, OpDivu = 2'd1, OpRem = 2'd2, OpRemu = 2'd3} op_e;

  typedef struct packed {
    logic             id;
    logic [TAG_W-1:0] tag;
    op_e              op;
    logic             special;
    logic [31:0]      sdata;
    logic             dbz;
  } trk_t;

  logic [Depth-1:0] vld_q, vld_d;
  trk_t [Depth-1:0] trk_q, trk_d;
  trk_t             new_trk, last;

  logic             rr_last_q, rr_last_d;
  logic [31:0]      numer_q, numer_d, denom_q, denom_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic             rsp_dbz_q, rsp_dbz_d;

  logic [1:0]       grant;
  logic             accept, sel;
  op_e              op_sel;
  logic [31:0]      a_sel, b_sel;
  logic [TAG_W-1:0] tag_sel;
  logic             is_special, spec_dbz;
  logic [31:0]      spec_data;

  // rr_last_q holds the last granted index; a tie goes to the other one.
  always_comb begin
    grant = 2'b00;
    unique case (i_req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr_last_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  assign o_req_ready = grant & {2{~i_flush}};
  assign accept      = |(i_req_valid & o_req_ready);
  assign sel         = grant[1];
  assign op_sel      = op_e'(sel ? i_req_op1 : i_req_op0);
  assign a_sel       = sel ? i_req_a1 : i_req_a0;
  assign b_sel       = sel ? i_req_b1 : i_req_b0;
  assign tag_sel     = sel ? i_req_tag1 : i_req_tag0;

  always_comb begin
    is_special = 1'b0;
    spec_dbz   = 1'b0;
    spec_data  = '0;
    if (b_sel == '0) begin
      is_special = 1'b1;
      spec_dbz   = 1'b1;
      spec_data  = (op_sel == OpDiv || op_sel == OpDivu) ? 32'hffff_ffff : a_sel;
    end else if ((op_sel == OpDiv || op_sel == OpRem) &&
                 a_sel == 32'h8000_0000 && b_sel == 32'hffff_ffff) begin
      is_special = 1'b1;
      spec_data  = (op_sel == OpDiv) ? 32'h8000_0000 : '0;
    end
  end

  always_comb begin
    new_trk = '{id: sel, tag: tag_sel, op: op_sel, special: is_special,
                sdata: spec_data, dbz: spec_dbz};
    vld_d     = i_flush ? '0 : {vld_q[Depth-2:0], accept};
    trk_d     = {trk_q[Depth-2:0], new_trk};
    rr_last_d = accept ? sel : rr_last_q;
    numer_d   = accept ? a_sel : numer_q;
    denom_d   = accept ? b_sel : denom_q;
  end

  // The last stage lines up with the divider outputs for the operands it issued with.
  always_comb begin
    last        = trk_q[Depth-1];
    rsp_valid_d = vld_q[Depth-1] & ~i_flush;
    rsp_id_d    = 1'b0;
    rsp_tag_d   = '0;
    rsp_data_d  = '0;
    rsp_dbz_d   = 1'b0;
    if (rsp_valid_d) begin
      rsp_id_d  = last.id;
      rsp_tag_d = last.tag;
      rsp_dbz_d = last.dbz;
      if (last.special) begin
        rsp_data_d = last.sdata;
      end else begin
        unique case (last.op)
          OpDiv:  rsp_data_d = i_sq;
          OpDivu: rsp_data_d = i_uq;
          OpRem:  rsp_data_d = i_sr;
          OpRemu: rsp_data_d = i_ur;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_q       <= '0;
      trk_q       <= '0;
      rr_last_q   <= 1'b1;
      numer_q     <= '0;
      denom_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_tag_q   <= '0;
      rsp_data_q  <= '0;
      rsp_dbz_q   <= 1'b0;
    end else begin
      vld_q       <= vld_d;
      trk_q       <= trk_d;
      rr_last_q   <= rr_last_d;
      numer_q     <= numer_d;
      denom_q     <= denom_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_data_q  <= rsp_data_d;
      rsp_dbz_q   <= rsp_dbz_d;
    end
  end

  assign o_div_numer = numer_q;
  assign o_div_denom = denom_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_id    = rsp_id_q;
  assign o_rsp_tag   = rsp_tag_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_dbz   = rsp_dbz_q;
  assign o_busy      = (|vld_q) | rsp_valid_q;

endmodule

// File: doc/muldiv_div_scheduler.md
Name: muldiv_div_scheduler

Overview:
- Shares one pair of pipelined 32-bit dividers (signed and unsigned, fixed latency, always clock-enabled) between two requesters: requester 0 is the CPU ALU, requester 1 is the auxiliary accelerator.
- Arbitrates round-robin, accepting at most one request per cycle.
- Computes the RISC-V special cases (divide-by-zero, signed overflow) in a bypass path.
- Tracks in-flight operations in a shift pipeline and returns tagged results in issue order at a fixed latency.

Parameters:
- DIV_LATENCY, 20, pipeline depth of the external dividers in cycles (≥1).
- TAG_W, 4, width of the requester-supplied tag.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_flush  in  1  synchronous kill of all in-flight ops; blocks acceptance this cycle
- i_req_valid  in  2  per-requester request valid
- o_req_ready  out  2  per-requester grant/accept (combinational)
- i_req_op0 / i_req_op1  in  2 each  0=DIV 1=DIVU 2=REM 3=REMU
- i_req_a0 / i_req_a1  in  32 each  dividend
- i_req_b0 / i_req_b1  in  32 each  divisor
- i_req_tag0 / i_req_tag1  in  TAG_W each  opaque tag
- o_div_numer  out  32  registered numerator to both dividers
- o_div_denom  out  32  registered denominator to both dividers
- i_sq, i_sr  in  32 each  signed divider quotient/remainder
- i_uq, i_ur  in  32 each  unsigned divider quotient/remainder
- o_rsp_valid  out  1  result valid, single-cycle pulse; no backpressure
- o_rsp_id  out  1  requester index
- o_rsp_tag  out  TAG_W  echoed tag
- o_rsp_data  out  32  result
- o_rsp_dbz  out  1  divisor was zero
- o_busy  out  1  any op in flight

Behaviour:
- Reset (async, i_rst_n=0): o_div_numer=0, o_div_denom=0, all pipeline valid bits=0, o_rsp_*=0, o_busy=0, round-robin pointer=1 (requester 0 wins first tie). Reset mid-operation drops all in-flight ops; no response is ever produced for them.
- Arbitration:
  - Grant goes to the single valid requester.
  - If both are valid, grant goes to the one not granted last.
  - o_req_ready[n] = grant[n] & ~i_flush.
  - Accept = valid & ready. The pointer updates only on accept.
  - Requesters must hold their signals until accepted.
- Issue (accept at cycle T): at T+1, o_div_numer/o_div_denom hold the operands, and a tracking stage loads {valid, id, tag, op, special, special_data, dbz}.
- Special cases, decided at accept:
  - b==0: DIV/DIVU → 0xFFFFFFFF, REM/REMU → a, dbz=1.
  - Signed only (op 0/2), a==0x80000000 and b==0xFFFFFFFF: DIV → 0x80000000, REM → 0. dbz=0.
  - Special ops still occupy a tracking slot and return at the normal latency, which preserves ordering.
- Tracking: a shift pipeline of depth DIV_LATENCY+1 advances every cycle; there is no stall.
- Response:
  - Latency: the response is registered at T+2+DIV_LATENCY.
  - Data source (non-special ops): op0 → i_sq, op1 → i_uq, op2 → i_sr, op3 → i_ur, sampled when the stage reaches divider-output alignment.
  - Special ops return special_data.
- Throughput: 1 op/cycle sustained, back-to-back.
- o_busy: OR of all tracking valid bits, plus o_rsp_valid.
- Flush:
  - i_flush=1 clears all tracking valid bits on the next edge.
  - o_rsp_valid is 0 on the cycle following flush.
  - No accept occurs in the flush cycle.
  - Results from flushed ops emerging from the dividers later are ignored.
- Simultaneous flush and accept cannot occur (ready is masked). Simultaneous flush and response-due: the response is suppressed.

Test Plan:
- Single DIV: req0 a=100, b=7, tag=3 at T → at T+22 (DIV_LATENCY=20): o_rsp_valid=1, id=0, tag=3, data=14, dbz=0. No other pulses.
- Divide-by-zero: req1 DIVU a=55, b=0 → data=0xFFFFFFFF, dbz=1. Then REMU a=55, b=0 → data=55, dbz=1. Both arrive at normal latency and in order.
- Overflow: DIV a=0x80000000, b=0xFFFFFFFF → data=0x80000000. REM with the same operands → data=0, dbz=0.
- Contention: both requesters valid continuously for 6 cycles, ops REM 17/5 (req0) and REMU 17/5 (req1) → grants alternate 0,1,0,1,0,1. Six responses arrive on consecutive cycles, id alternating 0,1,…, all data=2.
- Flush: issue 3 ops back-to-back, then assert i_flush for 1 cycle at T+5 → no responses for those ops. An op accepted at T+6 returns normally at T+28. o_busy falls after flush and rises again on the new accept.
- Reset mid-flight: issue an op, then pulse i_rst_n low at T+10 asynchronously (between clock edges) → outputs are 0 immediately, no response appears, and the next request after reset is granted to requester 0 if both are valid.
